obi_wait_responder: RTL and testbench

Parameterizable OBI slave endpoint: a word-addressed, byte-enabled scratch memory that answers one OBI slave port of the system crossbar. It inserts a programmable number of grant wait states and a fixed response latency. It serves as a real scratchpad and as a timing-stress target for crossbar and master verification. It sits on any `slave_req_o[k]`/`slave_resp_i[k]` pair of the crossbar.

---
 rtl/obi_pkg.sv | 20 ++
 rtl/obi_wait_responder.sv | 89 ++++++++
 tb/tb_obi_wait_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by crossbar ports and endpoints.
// Pure type definitions, no logic and no latency.
// No rready: responses are accepted unconditionally by the requester.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_wait_responder.sv
// OBI slave scratchpad: byte-enabled word memory with programmable grant wait states.
// Latency: gnt after GntWait cycles of held req; rvalid exactly Latency cycles after handshake.
// Backpressure: only via withheld gnt; responses cannot be stalled (no rready), up to Latency in flight.
module obi_wait_responder #(
  parameter int          NumWords = 256,
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int          GntWait  = 0,
  parameter int          Latency  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  obi_pkg::obi_req_t   slave_req_i,
  output obi_pkg::obi_resp_t  slave_resp_o
);

  localparam int          AW        = $clog2(NumWords);
  localparam logic [31:0] SpanBytes = 32'(NumWords * 4);
  localparam logic [3:0]  WaitCnt   = 4'(GntWait);
  localparam logic [31:0] OorData   = 32'hBADACCE5;

  logic [3:0]    wcnt_q;
  logic          gnt;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rsp_dat;

  logic [31:0]        mem_q [NumWords];
  logic [Latency-1:0] vld_q;
  logic [31:0]        dat_q [Latency];

  // gnt already includes req, so gnt alone marks a handshake cycle.
  assign gnt      = slave_req_i.req && (wcnt_q == WaitCnt);
  assign offset   = slave_req_i.addr - BaseAddr;
  assign in_range = (offset < SpanBytes);
  assign idx      = offset[AW+1:2];

  // Wait counter: restarts on idle or after each handshake so every request waits the full GntWait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= 4'd0;
    end else if (!slave_req_i.req || gnt) begin
      wcnt_q <= 4'd0;
    end else begin
      wcnt_q <= wcnt_q + 4'd1;
    end
  end

  // Memory array is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && gnt && slave_req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_req_i.be[b]) begin
          mem_q[idx][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response payload: reads see the word as stored before this edge; writes answer zero.
  always_comb begin
    rsp_dat = 32'h0;
    if (!slave_req_i.we) begin
      rsp_dat = in_range ? mem_q[idx] : OorData;
    end
  end

  // Response shift register: stage 0 loads on the handshake, last stage drives the port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= 32'h0;
      end
    end else begin
      vld_q[0] <= gnt;
      dat_q[0] <= rsp_dat;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = vld_q[Latency-1];
  assign slave_resp_o.rdata  = dat_q[Latency-1];

endmodule

// File: tb/tb_obi_wait_responder.sv
// Directed bench for obi_wait_responder across three parameter sets.
// Instance 0: GntWait=3 Latency=2; 1: GntWait=0 Latency=4; 2: BaseAddr=0x2000 GntWait=1 Latency=3.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the falling edge.
module tb_obi_wait_responder;
  import obi_pkg::*;

  logic      clk;
  logic      rst  [3];
  obi_req_t  req  [3];
  obi_resp_t resp [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  int          w;
  int          l;
  int          seen;
  int          gseen;
  int          rv_cyc [$];
  logic [31:0] rv_dat [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obi_wait_responder #(.NumWords(16), .BaseAddr(32'h0), .GntWait(3), .Latency(2)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .slave_req_i(req[0]), .slave_resp_o(resp[0]));
  obi_wait_responder #(.NumWords(256), .BaseAddr(32'h0), .GntWait(0), .Latency(4)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .slave_req_i(req[1]), .slave_resp_o(resp[1]));
  obi_wait_responder #(.NumWords(256), .BaseAddr(32'h2000), .GntWait(1), .Latency(3)) u_c (
    .clk_i(clk), .rst_i(rst[2]), .slave_req_i(req[2]), .slave_resp_o(resp[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: hold req until gnt, then wait for the single rvalid (both bounded).
  task automatic xfer(input int k, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdo, output int waits, output int lat);
    req[k] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
    waits = 0;
    #4;
    while (!resp[k].gnt && waits < 20) begin
      @(posedge clk); #5;
      waits++;
    end
    @(posedge clk); #1;
    req[k].req = 1'b0;
    lat = 1;
    #4;
    while (!resp[k].rvalid && lat < 20) begin
      @(posedge clk); #5;
      lat++;
    end
    rdo = resp[k].rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      req[k] = '0;
    end
    req[0].req = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    // ---- reset state with req held high ----
    check("rst_gnt_a",    32'(resp[0].gnt),    32'd0);
    check("rst_rvalid_a", 32'(resp[0].rvalid), 32'd0);
    check("rst_rdata_a",  resp[0].rdata,       32'h0);
    check("rst_rdata_b",  resp[1].rdata,       32'h0);
    @(posedge clk); #1;
    req[0].req = 1'b0;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #4;
      for (int k = 0; k < 3; k++) if (resp[k].rvalid) seen++;
      @(posedge clk); #1;
    end
    check("no_spurious_rvalid", 32'(seen), 32'd0);

    // ---- byte enables, wait states and latency on instance 0 ----
    xfer(0, 1'b1, 4'hF, 32'h0000_000C, 32'hDEADBEEF, rd, w, l);
    check("be_wr1_wait", 32'(w), 32'd3);
    check("be_wr1_lat",  32'(l), 32'd2);
    check("be_wr1_data", rd, 32'h0);
    xfer(0, 1'b1, 4'b0100, 32'h0000_000C, 32'h00AA0000, rd, w, l);
    check("be_wr2_lat", 32'(l), 32'd2);
    xfer(0, 1'b0, 4'h0, 32'h0000_000C, 32'h0, rd, w, l);
    check("be_rd_wait", 32'(w), 32'd3);
    check("be_rd_lat",  32'(l), 32'd2);
    check("be_rd_data", rd, 32'hDEAABEEF);

    // ---- request withdrawn before gnt: no access, no response ----
    req[0] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h0000_000C, wdata: 32'h0};
    gseen = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) req[0].req = 1'b0;
      #4;
      if (resp[0].gnt) gseen++;
      if (resp[0].rvalid) seen++;
      @(posedge clk); #1;
    end
    check("drop_no_gnt",    32'(gseen), 32'd0);
    check("drop_no_rvalid", 32'(seen),  32'd0);
    xfer(0, 1'b0, 4'hF, 32'h0000_000C, 32'h0, rd, w, l);
    check("drop_mem_kept", rd, 32'hDEAABEEF);

    // ---- back-to-back reads on instance 1 ----
    for (int i = 0; i < 8; i++) begin
      xfer(1, 1'b1, 4'hF, 32'(i * 4), 32'h1000_0000 + 32'(i), rd, w, l);
    end
    check("b2b_wr_lat", 32'(l), 32'd4);
    rv_cyc.delete();
    rv_dat.delete();
    for (int c = 0; c < 16; c++) begin
      if (c < 8) req[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'(c * 4), wdata: 32'h0};
      else req[1].req = 1'b0;
      #4;
      if (resp[1].rvalid) begin
        rv_cyc.push_back(c);
        rv_dat.push_back(resp[1].rdata);
      end
      @(posedge clk); #1;
    end
    check("b2b_count", 32'(rv_cyc.size()), 32'd8);
    for (int i = 0; i < rv_cyc.size() && i < 8; i++) begin
      check($sformatf("b2b_cyc%0d", i), 32'(rv_cyc[i]), 32'(4 + i));
      check($sformatf("b2b_dat%0d", i), rv_dat[i], 32'h1000_0000 + 32'(i));
    end

    // ---- write then read of the same word on consecutive cycles ----
    rv_cyc.delete();
    rv_dat.delete();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) req[1] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h4, wdata: 32'hCAFEF00D};
      else if (c == 1) req[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h4, wdata: 32'h0};
      else req[1].req = 1'b0;
      #4;
      if (resp[1].rvalid) begin
        rv_cyc.push_back(c);
        rv_dat.push_back(resp[1].rdata);
      end
      @(posedge clk); #1;
    end
    check("raw_count", 32'(rv_cyc.size()), 32'd2);
    if (rv_cyc.size() == 2) begin
      check("raw_wr_cyc", 32'(rv_cyc[0]), 32'd4);
      check("raw_wr_dat", rv_dat[0], 32'h0);
      check("raw_rd_cyc", 32'(rv_cyc[1]), 32'd5);
      check("raw_rd_dat", rv_dat[1], 32'hCAFEF00D);
    end

    // ---- address window on instance 2 ----
    xfer(2, 1'b1, 4'hF, 32'h0000_2000, 32'h1111_1111, rd, w, l);
    check("c_wr0_wait", 32'(w), 32'd1);
    check("c_wr0_lat",  32'(l), 32'd3);
    xfer(2, 1'b1, 4'hF, 32'h0000_2400, 32'h1234_5678, rd, w, l);
    check("oor_wr_lat",  32'(l), 32'd3);
    check("oor_wr_data", rd, 32'h0);
    xfer(2, 1'b0, 4'hF, 32'h0000_2000, 32'h0, rd, w, l);
    check("oor_wr_no_alias", rd, 32'h1111_1111);
    xfer(2, 1'b0, 4'hF, 32'h0000_1FFC, 32'h0, rd, w, l);
    check("oor_rd_below", rd, 32'hBADACCE5);
    xfer(2, 1'b0, 4'hF, 32'h0000_2400, 32'h0, rd, w, l);
    check("oor_rd_above", rd, 32'hBADACCE5);
    xfer(2, 1'b1, 4'hF, 32'h0000_23FC, 32'hA5A5_5A5A, rd, w, l);
    xfer(2, 1'b0, 4'hF, 32'h0000_23FE, 32'h0, rd, w, l);
    check("top_word_rd", rd, 32'hA5A5_5A5A);

    // ---- reset one cycle after a read handshake drops its response ----
    xfer(2, 1'b1, 4'hF, 32'h0000_2004, 32'h7777_8888, rd, w, l);
    req[2] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_2004, wdata: 32'h0};
    w = 0;
    #4;
    while (!resp[2].gnt && w < 20) begin
      @(posedge clk); #5;
      w++;
    end
    check("mid_gnt_wait", 32'(w), 32'd1);
    @(posedge clk); #1;
    req[2].req = 1'b0;
    rst[2] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rst[2] = 1'b0;
      #4;
      if (resp[2].rvalid) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_rvalid", 32'(seen), 32'd0);
    xfer(2, 1'b0, 4'hF, 32'h0000_2004, 32'h0, rd, w, l);
    check("mid_rst_mem_kept", rd, 32'h7777_8888);
    check("mid_rst_lat", 32'(l), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
